round_sequencer: RTL and testbench

- Control FSM for the 21 card game.
- Sequences the card-source datapath through a draw_req/card_valid handshake.
- Accumulates player and dealer scores, runs the dealer's automatic draw policy and decides the outcome.
- Sits between the debounced/inverted KEY inputs and the card source; drives the score/turn/outcome hex decoders.

---
 rtl/round_pkg.sv | 40 ++++
 rtl/btn_edge.sv | 24 ++
 rtl/round_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_round_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_pkg.sv
// Shared types, codes and widths for the 21 card game round sequencer.
// No logic: states, turn/outcome encodings and the no-bust score compare.
// Imported by round_sequencer and its testbench.
package round_pkg;

  localparam int SCORE_W = 6;
  localparam int CARD_W  = 4;

  typedef enum logic [2:0] {
    P_WAIT  = 3'd0,
    P_REQ   = 3'd1,
    P_ADD   = 3'd2,
    D_CHECK = 3'd3,
    D_REQ   = 3'd4,
    D_ADD   = 3'd5,
    D_PAUSE = 3'd6,
    RESULT  = 3'd7
  } state_e;

  localparam logic [2:0] TURN_PLAYER = 3'b000;
  localparam logic [2:0] TURN_DEALER = 3'b010;
  localparam logic [2:0] TURN_END    = 3'b100;

  localparam logic [1:0] OUT_NONE   = 2'b00;
  localparam logic [1:0] OUT_PLAYER = 2'b01;
  localparam logic [1:0] OUT_DEALER = 2'b10;
  localparam logic [1:0] OUT_PUSH   = 2'b11;

  // Outcome of a round where neither side has bust: higher total wins.
  function automatic logic [1:0] compare_scores(input logic [SCORE_W-1:0] player,
                                                input logic [SCORE_W-1:0] dealer);
    if (player > dealer) begin
      return OUT_PLAYER;
    end else if (dealer > player) begin
      return OUT_DEALER;
    end
    return OUT_PUSH;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Button register plus rising-edge detector; one pulse per press however long it is held.
// Latency: pulse is combinational in the cycle the level first reads high.
// No backpressure: a pulse that the consumer ignores is simply lost.
module btn_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);

  logic btn_q;

  // Remember last cycle's button level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn_i;
    end
  end

  assign rise_o = btn_i & ~btn_q;

endmodule

// File: rtl/round_sequencer.sv
// Round control FSM for 21: player draws/holds, dealer auto-draws to DEALER_STAND, outcome decided.
// Latency: card accepted in the card_valid cycle, added to the score the following cycle.
// Backpressure: draw_req held until card_valid with a nonzero card; optional ROUND_SEQ_DEALER_PAUSE_EN adds a dealer pause.
module round_sequencer
    import round_pkg::*;
#(
    parameter int unsigned DEALER_STAND = 17,
    parameter int unsigned BUST_LIMIT   = 21,
    parameter int unsigned PAUSE_CYCLES = 25000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               next_btn,
    input  logic               draw_btn,
    input  logic               card_valid,
    input  logic [CARD_W-1:0]  card_in,
    output logic               draw_req,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] dealer_score,
    output logic [CARD_W-1:0]  last_card,
    output logic [2:0]         turn,
    output logic [1:0]         outcome
);

    localparam logic [SCORE_W-1:0] STAND_L = SCORE_W'(DEALER_STAND);
    localparam logic [SCORE_W-1:0] BUST_L  = SCORE_W'(BUST_LIMIT);

    state_e               state_q, state_d;
    logic [SCORE_W-1:0]   player_q, player_d;
    logic [SCORE_W-1:0]   dealer_q, dealer_d;
    logic [CARD_W-1:0]    last_q, last_d;
    logic [1:0]           outcome_q, outcome_d;
    logic                 draw_ev, next_ev;
    logic                 card_ok;
    logic [SCORE_W-1:0]   card_ext, player_sum, dealer_sum;

`ifdef ROUND_SEQ_DEALER_PAUSE_EN
    localparam logic [24:0] PAUSE_LOAD = 25'(PAUSE_CYCLES - 1);
    logic [24:0]          pause_q, pause_d;
`endif

    btn_edge u_draw_edge (
        .clk_i  (clock),
        .rst_i  (reset),
        .btn_i  (draw_btn),
        .rise_o (draw_ev)
    );

    btn_edge u_next_edge (
        .clk_i  (clock),
        .rst_i  (reset),
        .btn_i  (next_btn),
        .rise_o (next_ev)
    );

    // A zero card is not a legal value; keep requesting until a real one arrives.
    assign card_ok    = card_valid && (card_in != '0);
    assign card_ext   = {{(SCORE_W-CARD_W){1'b0}}, last_q};
    assign player_sum = player_q + card_ext;
    assign dealer_sum = dealer_q + card_ext;

    assign player_score = player_q;
    assign dealer_score = dealer_q;
    assign last_card    = last_q;
    assign outcome      = outcome_q;

    // State and datapath registers; reset also drops draw_req since it decodes from state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= P_WAIT;
            player_q  <= '0;
            dealer_q  <= '0;
            last_q    <= '0;
            outcome_q <= OUT_NONE;
`ifdef ROUND_SEQ_DEALER_PAUSE_EN
            pause_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            player_q  <= player_d;
            dealer_q  <= dealer_d;
            last_q    <= last_d;
            outcome_q <= outcome_d;
`ifdef ROUND_SEQ_DEALER_PAUSE_EN
            pause_q   <= pause_d;
`endif
        end
    end

    // Next-state, score updates and the decoded draw_req/turn outputs.
    always_comb begin
        state_d   = state_q;
        player_d  = player_q;
        dealer_d  = dealer_q;
        last_d    = last_q;
        outcome_d = outcome_q;
`ifdef ROUND_SEQ_DEALER_PAUSE_EN
        pause_d   = pause_q;
`endif
        draw_req  = 1'b0;
        turn      = TURN_PLAYER;

        case (state_q)
            P_WAIT: begin
                // Draw takes priority over hold when both are pressed together.
                if (draw_ev) begin
                    state_d = P_REQ;
                end else if (next_ev) begin
                    state_d = D_CHECK;
                end
            end
            P_REQ: begin
                draw_req = 1'b1;
                if (card_ok) begin
                    last_d  = card_in;
                    state_d = P_ADD;
                end
            end
            P_ADD: begin
                player_d = player_sum;
                if (player_sum > BUST_L) begin
                    outcome_d = OUT_DEALER;
                    state_d   = RESULT;
                end else begin
                    state_d = P_WAIT;
                end
            end
            D_CHECK: begin
                turn = TURN_DEALER;
                if (dealer_q > BUST_L) begin
                    outcome_d = OUT_PLAYER;
                    state_d   = RESULT;
                end else if (dealer_q >= STAND_L) begin
                    outcome_d = compare_scores(player_q, dealer_q);
                    state_d   = RESULT;
                end else begin
                    state_d = D_REQ;
                end
            end
            D_REQ: begin
                turn     = TURN_DEALER;
                draw_req = 1'b1;
                if (card_ok) begin
                    last_d  = card_in;
                    state_d = D_ADD;
                end
            end
            D_ADD: begin
                turn     = TURN_DEALER;
                dealer_d = dealer_sum;
`ifdef ROUND_SEQ_DEALER_PAUSE_EN
                pause_d  = PAUSE_LOAD;
                state_d  = D_PAUSE;
`else
                state_d  = D_CHECK;
`endif
            end
            D_PAUSE: begin
                turn = TURN_DEALER;
`ifdef ROUND_SEQ_DEALER_PAUSE_EN
                // Hold the dealer's card on the display before deciding the next draw.
                if (pause_q == '0) begin
                    state_d = D_CHECK;
                end else begin
                    pause_d = pause_q - 25'd1;
                end
`else
                state_d = D_CHECK;
`endif
            end
            RESULT: begin
                turn = TURN_END;
                if (next_ev) begin
                    player_d  = '0;
                    dealer_d  = '0;
                    last_d    = '0;
                    outcome_d = OUT_NONE;
                    state_d   = P_WAIT;
                end
            end
            default: begin
                state_d = P_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed self-checking bench for round_sequencer.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Dealer inter-draw gap expectation follows ROUND_SEQ_DEALER_PAUSE_EN (PAUSE_CYCLES = 4 there).
module tb_round_sequencer;
    import round_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       next_btn = 1'b0;
    logic       draw_btn = 1'b0;
    logic       card_valid = 1'b0;
    logic [3:0] card_in = 4'd0;
    logic       draw_req;
    logic [5:0] player_score;
    logic [5:0] dealer_score;
    logic [3:0] last_card;
    logic [2:0] turn;
    logic [1:0] outcome;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int BOUND = 200;
`ifdef ROUND_SEQ_DEALER_PAUSE_EN
    localparam int EXP_GAP = 6;
`else
    localparam int EXP_GAP = 2;
`endif

    round_sequencer #(.PAUSE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .next_btn     (next_btn),
        .draw_btn     (draw_btn),
        .card_valid   (card_valid),
        .card_in      (card_in),
        .draw_req     (draw_req),
        .player_score (player_score),
        .dealer_score (dealer_score),
        .last_card    (last_card),
        .turn         (turn),
        .outcome      (outcome)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    // Wait for draw_req, optionally stall, then present one card for one cycle.
    task automatic serve_card(input logic [3:0] v, input int delay, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (draw_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) return;
        repeat (delay) tick();
        card_valid = 1'b1;
        card_in    = v;
        tick();
        card_valid = 1'b0;
        card_in    = 4'd0;
    endtask

    task automatic player_draw(input logic [3:0] v, output bit ok);
        draw_btn = 1'b1;
        tick();
        draw_btn = 1'b0;
        serve_card(v, 0, ok);
        tick();
    endtask

    task automatic press_next();
        next_btn = 1'b1;
        tick();
        next_btn = 1'b0;
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (turn === TURN_END) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (draw_req !== 1'b0) begin n_fail++; $display("FAIL reset_draw_req got %b want 0", draw_req); end
        n_checks++; if (player_score !== 6'd0) begin n_fail++; $display("FAIL reset_player got %0d want 0", player_score); end
        n_checks++; if (dealer_score !== 6'd0) begin n_fail++; $display("FAIL reset_dealer got %0d want 0", dealer_score); end
        n_checks++; if (last_card !== 4'd0) begin n_fail++; $display("FAIL reset_last got %0d want 0", last_card); end
        n_checks++; if (turn !== 3'b000) begin n_fail++; $display("FAIL reset_turn got %b want 000", turn); end
        n_checks++; if (outcome !== 2'b00) begin n_fail++; $display("FAIL reset_outcome got %b want 00", outcome); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_round();
        bit ok1, ok2, ok3, ok4, ok5;
        int gap;
        player_draw(4'd10, ok1);
        player_draw(4'd9, ok2);
        n_checks++; if ({ok1, ok2} !== 2'b11) begin n_fail++; $display("FAIL basic_player_timeout got %b want 11", {ok1, ok2}); end
        n_checks++; if (player_score !== 6'd19) begin n_fail++; $display("FAIL basic_player_mid got %0d want 19", player_score); end
        n_checks++; if (last_card !== 4'd9) begin n_fail++; $display("FAIL basic_last_mid got %0d want 9", last_card); end
        n_checks++; if (turn !== 3'b000 || outcome !== 2'b00) begin n_fail++; $display("FAIL basic_in_play got turn %b outcome %b want 000 00", turn, outcome); end
        press_next();
        serve_card(4'd10, 0, ok3);
        gap = 0;
        while (!draw_req && gap < BOUND) begin
            gap++;
            tick();
        end
        n_checks++; if (gap !== EXP_GAP) begin n_fail++; $display("FAIL dealer_gap got %0d want %0d", gap, EXP_GAP); end
        serve_card(4'd7, 0, ok4);
        wait_end(ok5);
        n_checks++; if ({ok3, ok4, ok5} !== 3'b111) begin n_fail++; $display("FAIL basic_dealer_timeout got %b want 111", {ok3, ok4, ok5}); end
        n_checks++; if (player_score !== 6'd19) begin n_fail++; $display("FAIL basic_player got %0d want 19", player_score); end
        n_checks++; if (dealer_score !== 6'd17) begin n_fail++; $display("FAIL basic_dealer got %0d want 17", dealer_score); end
        n_checks++; if (outcome !== 2'b01) begin n_fail++; $display("FAIL basic_outcome got %b want 01", outcome); end
        n_checks++; if (turn !== 3'b100) begin n_fail++; $display("FAIL basic_turn got %b want 100", turn); end
        n_checks++; if (last_card !== 4'd7) begin n_fail++; $display("FAIL basic_last got %0d want 7", last_card); end
    endtask

    task automatic test_result_clear();
        draw_btn = 1'b1;
        tick();
        draw_btn = 1'b0;
        tick();
        n_checks++; if (turn !== 3'b100 || draw_req !== 1'b0) begin n_fail++; $display("FAIL result_draw_ignored got turn %b req %b want 100 0", turn, draw_req); end
        n_checks++; if (outcome !== 2'b01) begin n_fail++; $display("FAIL result_held got %b want 01", outcome); end
        press_next();
        n_checks++; if (player_score !== 6'd0 || dealer_score !== 6'd0) begin n_fail++; $display("FAIL clear_scores got %0d %0d want 0 0", player_score, dealer_score); end
        n_checks++; if (last_card !== 4'd0 || outcome !== 2'b00) begin n_fail++; $display("FAIL clear_last_outcome got %0d %b want 0 00", last_card, outcome); end
        n_checks++; if (turn !== 3'b000 || draw_req !== 1'b0) begin n_fail++; $display("FAIL clear_turn got %b req %b want 000 0", turn, draw_req); end
    endtask

    task automatic test_player_bust();
        bit ok1, ok2, ok3;
        int reqs;
        player_draw(4'd10, ok1);
        player_draw(4'd8, ok2);
        player_draw(4'd5, ok3);
        n_checks++; if ({ok1, ok2, ok3} !== 3'b111) begin n_fail++; $display("FAIL bust_timeout got %b want 111", {ok1, ok2, ok3}); end
        n_checks++; if (player_score !== 6'd23) begin n_fail++; $display("FAIL bust_player got %0d want 23", player_score); end
        n_checks++; if (outcome !== 2'b10) begin n_fail++; $display("FAIL bust_outcome got %b want 10", outcome); end
        n_checks++; if (turn !== 3'b100) begin n_fail++; $display("FAIL bust_turn got %b want 100", turn); end
        n_checks++; if (dealer_score !== 6'd0) begin n_fail++; $display("FAIL bust_dealer got %0d want 0", dealer_score); end
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            if (draw_req) reqs++;
            tick();
        end
        n_checks++; if (reqs !== 0) begin n_fail++; $display("FAIL bust_no_dealer_req got %0d want 0", reqs); end
        press_next();
    endtask

    // Player stands on p1+p2, dealer gets d[0..n-1]; returns when RESULT is reached.
    task automatic play_round(input logic [3:0] p1, input logic [3:0] p2,
                              input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input int nd, output bit ok);
        bit a, b, c, e, f, g;
        c = 1'b1;
        e = 1'b1;
        f = 1'b1;
        player_draw(p1, a);
        player_draw(p2, b);
        press_next();
        serve_card(d0, 0, c);
        serve_card(d1, 0, e);
        if (nd > 2) serve_card(d2, 0, f);
        wait_end(g);
        ok = a & b & c & e & f & g;
    endtask

    task automatic test_dealer_bust();
        bit ok;
        play_round(4'd10, 4'd8, 4'd6, 4'd5, 4'd13, 3, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dbust_timeout got %b want 1", ok); end
        n_checks++; if (dealer_score !== 6'd24) begin n_fail++; $display("FAIL dbust_dealer got %0d want 24", dealer_score); end
        n_checks++; if (player_score !== 6'd18) begin n_fail++; $display("FAIL dbust_player got %0d want 18", player_score); end
        n_checks++; if (outcome !== 2'b01) begin n_fail++; $display("FAIL dbust_outcome got %b want 01", outcome); end
        press_next();
    endtask

    task automatic test_push();
        bit ok;
        play_round(4'd10, 4'd8, 4'd10, 4'd8, 4'd0, 2, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL push_timeout got %b want 1", ok); end
        n_checks++; if (dealer_score !== 6'd18) begin n_fail++; $display("FAIL push_dealer got %0d want 18", dealer_score); end
        n_checks++; if (outcome !== 2'b11) begin n_fail++; $display("FAIL push_outcome got %b want 11", outcome); end
        press_next();
    endtask

    task automatic test_exact_21();
        bit ok1, ok2, ok3, ok4, ok5;
        player_draw(4'd10, ok1);
        player_draw(4'd11, ok2);
        n_checks++; if (player_score !== 6'd21 || turn !== 3'b000 || outcome !== 2'b00) begin n_fail++; $display("FAIL p21_not_bust got %0d %b %b want 21 000 00", player_score, turn, outcome); end
        press_next();
        serve_card(4'd13, 0, ok3);
        serve_card(4'd8, 0, ok4);
        wait_end(ok5);
        n_checks++; if ({ok1, ok2, ok3, ok4, ok5} !== 5'b11111) begin n_fail++; $display("FAIL e21_timeout got %b want 11111", {ok1, ok2, ok3, ok4, ok5}); end
        n_checks++; if (dealer_score !== 6'd21 || outcome !== 2'b11) begin n_fail++; $display("FAIL d21_push got %0d %b want 21 11", dealer_score, outcome); end
        press_next();
    endtask

    task automatic test_dealer_wins();
        bit ok;
        play_round(4'd10, 4'd5, 4'd10, 4'd9, 4'd0, 2, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dwin_timeout got %b want 1", ok); end
        n_checks++; if (dealer_score !== 6'd19 || player_score !== 6'd15) begin n_fail++; $display("FAIL dwin_scores got %0d %0d want 15 19", player_score, dealer_score); end
        n_checks++; if (outcome !== 2'b10) begin n_fail++; $display("FAIL dwin_outcome got %b want 10", outcome); end
        press_next();
    endtask

    task automatic test_draw_priority();
        bit ok;
        draw_btn = 1'b1;
        next_btn = 1'b1;
        tick();
        draw_btn = 1'b0;
        next_btn = 1'b0;
        n_checks++; if (draw_req !== 1'b1 || turn !== 3'b000) begin n_fail++; $display("FAIL prio_draw got req %b turn %b want 1 000", draw_req, turn); end
        serve_card(4'd3, 0, ok);
        tick();
        n_checks++; if (ok !== 1'b1 || player_score !== 6'd3) begin n_fail++; $display("FAIL prio_player got ok %b score %0d want 1 3", ok, player_score); end
    endtask

    task automatic test_hold();
        int acc, rises;
        logic prev;
        acc = 0;
        rises = 0;
        prev = 1'b0;
        draw_btn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (draw_req && !prev) rises++;
            prev = draw_req;
            if (draw_req) begin
                card_valid = 1'b1;
                card_in    = 4'd2;
                acc++;
            end else begin
                card_valid = 1'b0;
                card_in    = 4'd0;
            end
        end
        draw_btn   = 1'b0;
        card_valid = 1'b0;
        card_in    = 4'd0;
        tick();
        tick();
        n_checks++; if (rises !== 1 || acc !== 1) begin n_fail++; $display("FAIL hold_one_txn got rises %0d accepts %0d want 1 1", rises, acc); end
        n_checks++; if (player_score !== 6'd5) begin n_fail++; $display("FAIL hold_player got %0d want 5", player_score); end
    endtask

    task automatic test_delay();
        int high;
        high = 0;
        draw_btn = 1'b1;
        tick();
        draw_btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (draw_req) high++;
            card_valid = draw_req && (high == 6);
            card_in    = (draw_req && (high == 6)) ? 4'd1 : 4'd0;
            tick();
        end
        card_valid = 1'b0;
        card_in    = 4'd0;
        n_checks++; if (high !== 6) begin n_fail++; $display("FAIL delay_req_cycles got %0d want 6", high); end
        n_checks++; if (player_score !== 6'd6 || last_card !== 4'd1) begin n_fail++; $display("FAIL delay_one_add got %0d last %0d want 6 1", player_score, last_card); end
    endtask

    task automatic test_zero_card();
        draw_btn = 1'b1;
        tick();
        draw_btn   = 1'b0;
        card_valid = 1'b1;
        card_in    = 4'd0;
        repeat (3) tick();
        n_checks++; if (draw_req !== 1'b1 || player_score !== 6'd6 || last_card !== 4'd1) begin n_fail++; $display("FAIL zero_ignored got req %b score %0d last %0d want 1 6 1", draw_req, player_score, last_card); end
        card_in = 4'd4;
        tick();
        card_valid = 1'b0;
        card_in    = 4'd0;
        tick();
        n_checks++; if (player_score !== 6'd10 || last_card !== 4'd4) begin n_fail++; $display("FAIL zero_then_real got %0d last %0d want 10 4", player_score, last_card); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        press_next();
        ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            if (draw_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++; if (ok !== 1'b1 || turn !== 3'b010) begin n_fail++; $display("FAIL mid_dreq got ok %b turn %b want 1 010", ok, turn); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (draw_req !== 1'b0) begin n_fail++; $display("FAIL mid_async_req got %b want 0", draw_req); end
        n_checks++; if (player_score !== 6'd0 || dealer_score !== 6'd0 || turn !== 3'b000) begin n_fail++; $display("FAIL mid_async_state got %0d %0d %b want 0 0 000", player_score, dealer_score, turn); end
        #1 reset = 1'b0;
        tick();
        tick();
        n_checks++; if (turn !== 3'b000 || draw_req !== 1'b0 || outcome !== 2'b00) begin n_fail++; $display("FAIL mid_after got turn %b req %b out %b want 000 0 00", turn, draw_req, outcome); end
    endtask

    initial begin
        test_reset();
        test_basic_round();
        test_result_clear();
        test_player_bust();
        test_dealer_bust();
        test_push();
        test_exact_21();
        test_dealer_wins();
        test_draw_priority();
        test_hold();
        test_delay();
        test_zero_card();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
